// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: architectural widths and the multiply/divide
// unit's operation and state encodings.
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_LOC_BITS = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide stage: one shift-add or restoring-divide
// step per cycle on operand magnitudes, result written back to the register file.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH    = XLEN,
  parameter int LOC_BITS = REG_LOC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [LOC_BITS-1:0] dest_location,
  input  logic                flush,
  output logic                busy,
  output logic                write_enabled,
  output logic [LOC_BITS-1:0] write_location,
  output logic [WIDTH-1:0]    write_data
);

  localparam int CNT_BITS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t         state_reg, state_next;
  muldiv_op_t            op_reg, op_in;
  logic [LOC_BITS-1:0]   dest_reg;
  logic [2*WIDTH-1:0]    acc_reg, acc_step;
  logic [WIDTH-1:0]      operand_reg;
  logic [CNT_BITS-1:0]   cnt_reg;
  logic                  neg_main_reg, neg_rem_reg;
  logic                  accept;
  logic                  write_enabled_reg;
  logic [LOC_BITS-1:0]   write_location_reg;
  logic [WIDTH-1:0]      write_data_reg;

  logic                  is_div, div_signed, signed_a, signed_b, neg_a, neg_b;
  logic                  div_zero, div_ovf, fast_path;
  logic [WIDTH-1:0]      mag_a, mag_b;

  assign op_in = muldiv_op_t'(op);

  always_comb begin
    is_div     = op[2];
    div_signed = op[2] & ~op[0];
    signed_a   = (op_in == OP_MULH) || (op_in == OP_MULHSU) || div_signed;
    signed_b   = (op_in == OP_MULH) || div_signed;
    neg_a      = signed_a & operand_a[WIDTH-1];
    neg_b      = signed_b & operand_b[WIDTH-1];
    mag_a      = neg_a ? -operand_a : operand_a;
    mag_b      = neg_b ? -operand_b : operand_b;
    div_zero   = is_div && (operand_b == '0);
    div_ovf    = div_signed && (operand_a == MIN_NEG) && (operand_b == '1);
    fast_path  = div_zero | div_ovf;
  end

  assign start_ready    = (state_reg == IDLE) & reset;
  assign busy           = (state_reg != IDLE);
  assign write_enabled  = write_enabled_reg;
  assign write_location = write_location_reg;
  assign write_data     = write_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_valid && !flush) begin
          accept     = 1'b1;
          state_next = fast_path ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush)                state_next = IDLE;
        else if (cnt_reg == '0)   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply shifts right adding the multiplicand; divide shifts left and
  // keeps the trial subtraction when it does not go negative.
  logic [WIDTH:0]   add_sum, trial;
  logic [2*WIDTH:0] shifted;

  always_comb begin
    add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
            + ({(WIDTH+1){acc_reg[0]}} & {1'b0, operand_reg});
    shifted = {acc_reg, 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, operand_reg};
    if (op_reg[2])
      acc_step = trial[WIDTH] ? shifted[2*WIDTH-1:0]
                              : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    else
      acc_step = {add_sum, acc_reg[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, result;

  always_comb begin
    prod = neg_main_reg ? -acc_reg : acc_reg;
    quot = neg_main_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem  = neg_rem_reg  ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    unique case (op_reg)
      OP_MUL:                        result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               result = quot;
      default:                       result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg       <= OP_MUL;
      dest_reg     <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      cnt_reg      <= '0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
    end else if (accept) begin
      op_reg       <= op_in;
      dest_reg     <= dest_location;
      cnt_reg      <= CNT_BITS'(WIDTH-1);
      neg_main_reg <= neg_a ^ neg_b;
      neg_rem_reg  <= neg_a;
      // Fast-path results are preloaded raw, so sign fix-up is disabled.
      if (div_zero) begin
        acc_reg      <= {operand_a, {WIDTH{1'b1}}};
        neg_main_reg <= 1'b0;
        neg_rem_reg  <= 1'b0;
      end else if (div_ovf) begin
        acc_reg      <= {{WIDTH{1'b0}}, MIN_NEG};
        neg_main_reg <= 1'b0;
        neg_rem_reg  <= 1'b0;
      end else if (is_div) begin
        acc_reg     <= {{WIDTH{1'b0}}, mag_a};
        operand_reg <= mag_b;
      end else begin
        acc_reg     <= {{WIDTH{1'b0}}, mag_b};
        operand_reg <= mag_a;
      end
    end else if (state_reg == RUN) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  logic done_commit;
  assign done_commit = (state_reg == DONE) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enabled_reg  <= 1'b0;
      write_location_reg <= '0;
      write_data_reg     <= '0;
    end else begin
      write_enabled_reg <= done_commit && (dest_reg != '0);
      if (done_commit) begin
        write_location_reg <= dest_reg;
        write_data_reg     <= result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised scoreboard bench for muldiv_unit: the driver pushes expected
// writes (value, location, cycle), an independent monitor pops and compares.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  dest_location = '0;
  logic        start_ready, busy, write_enabled;
  logic [4:0]  write_location;
  logic [31:0] write_data;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .dest_location(dest_location), .flush(flush), .busy(busy),
    .write_enabled(write_enabled), .write_location(write_location),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  loc;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  string op_names[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, output int acc_cyc);
    int  waited = 0;
    bit  fast;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; dest_location = d; start_valid = 1'b1;
    while (!start_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!start_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout %s: start_ready=%b expected 1", op_names[o], start_ready);
      start_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start_valid = 1'b0;
    op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    dest_location = 5'($urandom);
    fast = (o[2] && b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    $display("issue %-6s a=%h b=%h rd=%0d at cycle %0d", op_names[o], a, b, d, acc_cyc);
    if (d != 0)
      sb_q.push_back('{d, ref_model(o, a, b), acc_cyc + (fast ? 1 : 33), op_names[o]});
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (write_enabled) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: rd=%0d data=%h expected no write", write_location, write_data);
      end else begin
        mon_e = sb_q.pop_front();
        $display("write %-6s rd=%0d data=%h at cycle %0d", mon_e.name, write_location, write_data, cyc);
        check({mon_e.name, "_loc"}, 32'(write_location), 32'(mon_e.loc));
        check({mon_e.name, "_data"}, write_data, mon_e.data);
        check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
        check({mon_e.name, "_ready_at_write"}, 32'(start_ready), 32'd1);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    int t1, t2, waited;
    logic [2:0]  o;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check("reset_start_ready", 32'(start_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_we", 32'(write_enabled), 32'd0);
    check("reset_loc", 32'(write_location), 32'd0);
    check("reset_data", write_data, 32'd0);
    reset = 1'b1;
    #1;
    check("post_reset_ready", 32'(start_ready), 32'd1);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, t1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, t1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, t1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, t1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, t1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, t1);
    issue(3'd5, 32'd100, 32'd7, 5'd7, t1);
    issue(3'd7, 32'd100, 32'd7, 5'd8, t1);
    issue(3'd5, 32'd5, 32'd0, 5'd9, t1);
    issue(3'd6, 32'd5, 32'd0, 5'd10, t1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, t1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, t1);

    // dest 0 runs silently; the held follow-up must wait for the unit
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, t1);
    issue(3'd5, 32'd1000, 32'd33, 5'd13, t2);
    check("held_issue_gap", 32'(t2 - t1), 32'd34);

    // flush in IDLE blocks the handshake
    @(negedge clk);
    op = 3'd0; operand_a = 32'd3; operand_b = 32'd3; dest_location = 5'd14;
    start_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 32'd0);

    // reset during RUN
    issue(3'd0, 32'd11, 32'd13, 5'd15, t1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_reset_busy", 32'(busy), 32'd0);
    check("abort_reset_we", 32'(write_enabled), 32'd0);
    check("abort_reset_ready", 32'(start_ready), 32'd0);
    sb_q.delete();
    @(negedge clk) reset = 1'b1;
    #1;
    check("abort_reset_ready_after", 32'(start_ready), 32'd1);
    repeat (40) @(negedge clk);

    // flush during RUN
    issue(3'd4, 32'd1000, 32'd7, 5'd16, t1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_run_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // flush during DONE of a fast-path op
    issue(3'd5, 32'd5, 32'd0, 5'd17, t1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_done_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      issue(o, a, b, 5'($urandom_range(0, 31)), t1);
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("pending_writes", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execute stage. It sits directly downstream of the register file: it consumes the two read-port operands plus the destination index, and it drives the register file write port (write_enabled, write_location, write_data) with the result. It uses a one-bit-per-cycle shift-add/restoring-divide datapath to keep area small. A valid/ready handshake stalls issue while the unit is busy.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified)
LOC_BITS, 5, register index width; matches the register file location ports

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
start_valid  input  1  issue request; operands, op and dest are valid this cycle
start_ready  output  1  unit idle and able to accept; the handshake fires when start_valid && start_ready
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operand_a  input  WIDTH  rs1 value (register file read1_out)
operand_b  input  WIDTH  rs2 value (register file read2_out)
dest_location  input  LOC_BITS  rd index
flush  input  1  synchronous cancel of the in-flight operation
busy  output  1  operation in flight (state != IDLE)
write_enabled  output  1  single-cycle write pulse to the register file
write_location  output  LOC_BITS  rd for the write
write_data  output  WIDTH  result

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, all datapath registers cleared. Outputs: start_ready=1 once reset is released (0 while in reset), busy=0, write_enabled=0, write_location=0, write_data=0. Reset mid-operation aborts the operation with no write.
- States:
  - IDLE: start_ready=1. On handshake, latch op, dest, operand magnitudes and result-sign flags.
    - Div-by-zero or signed overflow -> DONE.
    - Otherwise -> RUN, with counter=WIDTH-1.
  - RUN: one iteration per cycle. When counter==0 -> DONE, otherwise decrement counter.
  - DONE: write_enabled = (dest!=0). write_location and write_data are valid. Next state is IDLE.
- Outputs are registered. write_data and write_location hold their last values outside DONE; only write_enabled is a pulse.
- Latency: accept on edge E0. The write pulse occurs in the cycle after edge E(WIDTH+1), i.e. 33 cycles after the accepting edge for a normal op and 1 cycle after it for a fast-path op. start_ready returns to 1 in the cycle following DONE.
- Multiply: 2*WIDTH-bit product of the magnitudes.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Signedness: MULH treats both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU treats both as unsigned.
  - The product is negated (2*WIDTH-bit two's complement) when the operand signs differ.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Fast path (no RUN):
  - Divisor==0: quotient = all ones, remainder = operand_a.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- dest_location==0: the operation executes fully but write_enabled stays 0.
- start_valid while busy: ignored; no latch, and start_ready=0.
- flush: in RUN or DONE, the next state is IDLE and write_enabled is forced to 0 that cycle. flush in IDLE blocks the handshake that cycle.
- Operands are sampled only at the handshake; later changes to operand_a/b are ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - muldiv_op_t enum with the funct3 encodings above
  - muldiv_state_t enum {IDLE, RUN, DONE}
  - constants XLEN=32 and REG_LOC_BITS=5
- Single module. The datapath is small enough that no sub-module is warranted; the 2*WIDTH shift register is shared between multiply and divide.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD, dest=5 -> exactly one write_enabled pulse 33 cycles after accept; write_location=5, write_data=0xFFFFFFEB; start_ready back to 1 the next cycle.
2. High-half multiplies:
   - MULH 0x80000000*0x80000000 -> 0x40000000
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
3. Divides with a=-7 (0xFFFFFFF9), b=2:
   - DIV -> 0xFFFFFFFD
   - REM -> 0xFFFFFFFF
   - DIVU 100/7 -> 14; REMU 100/7 -> 2
4. Fast path:
   - DIVU 5/0 -> 0xFFFFFFFF
   - REM 5/0 -> 5
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
   - REM of the same operands -> 0
   - Each write occurs 1 cycle after accept.
5. MUL with dest=0 -> no write pulse, busy for 33 cycles. A second start_valid held during busy is not accepted until start_ready=1, and then produces its own correct result.
6. Abort:
   - reset driven low during RUN cycle 10 -> busy=0 and write_enabled=0 immediately, no write afterwards.
   - flush during RUN -> IDLE next cycle, no write pulse.
